grid2pos_scan: RTL
==================

Name: grid2pos_scan

Overview:
- Sequential inverse of the snake position-to-grid conversion.
- Snapshots a 16x16 occupancy grid and walks all 256 cells in row-major order.
- Emits the linear position of every matching cell on a valid/ready stream.
  - Occupied-cell mode: rebuilding or validating snake/obstacle lists.
  - Free-cell mode: food placement.
- Reports the match count when the scan finishes.
- Sits between the game logic's grid and the food generator / collision checker.

Parameters:
- GRID_DIM, 16, cells per row and per column. Fixed at 16 for this game; do not override.
- NUM_CELLS, 256, GRID_DIM*GRID_DIM.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- find_free  in  1  0: emit occupied cells (grid bit 1); 1: emit free cells (grid bit 0). Latched at start.
- abort  in  1  synchronous cancel of a scan in progress
- grid  in  16x16  occupancy grid. grid[row][col], row = pos/16, col = pos%16.
- pos_out  out  8  linear position of the current matching cell, row*16+col
- pos_valid  out  1  pos_out is a matching cell
- pos_ready  in  1  consumer accepts pos_out
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan completion
- count  out  9  number of matches accepted in the last scan, 0..256

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - State IDLE; pos_out=0, pos_valid=0, busy=0, done=0, count=0.
  - Internal idx=0; grid snapshot cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge loads the grid snapshot and latches find_free.
  - Same edge: idx=0, count=0, state->SCAN.
  - Inputs other than start are ignored.
- SCAN:
  - busy=1.
  - match = (snapshot[idx/16][idx%16] != find_free_q).
  - pos_out = idx at all times in SCAN.
  - pos_valid = match. Decoded from registered state only; no combinational path from pos_ready or grid to outputs.
  - Non-matching cell: idx advances after one cycle.
  - Matching cell: pos_out/pos_valid hold until pos_valid&&pos_ready. On that edge count+=1 and idx advances.
  - When idx=255 is consumed (skipped, or accepted on handshake) -> DONE; idx does not wrap into another pass.
- DONE:
  - busy=0, done=1 for exactly one cycle, then -> IDLE.
  - count holds its value until the next accepted start.
- abort=1 in SCAN:
  - Next state IDLE, no done pulse, pos_valid drops next cycle.
  - count keeps its partial value.
  - abort has priority over a simultaneous handshake; that transfer is not counted.
- Timing with pos_ready tied high: start accepted at edge E0. Cell k is examined in the cycle after edge E(k). DONE is the cycle after E256. Total 257 cycles, start to done.
- start while busy or in DONE: ignored, no queuing.
- grid changes after the start edge: no effect on the current scan (snapshot).
- Boundary cases:
  - All-zero grid with find_free=0: no pos_valid, done after 257 cycles, count=0.
  - Same grid with find_free=1: count=256. The count width must hold 256 without overflow.
- pos_ready while pos_valid=0: ignored.
- reset_n low mid-scan: immediate return to reset values. The partial scan is lost.

Decomposition:
- Shared package snake_pkg:
  - GRID_DIM=16, NUM_CELLS=256, POS_W=8, CNT_W=9.
  - typedef grid_t (logic [15:0][15:0]); typedef pos_t (logic [7:0]).
  - Enum scan_state_t {IDLE, SCAN, DONE}.
- Also reused by the position-to-grid converter and the food generator.
- No sub-module: one FSM, the snapshot register and the idx/count counters fit in one file.

Test Plan:
- Occupied mode, cells 0, 17, 255 set, find_free=0, pos_ready=1 -> pos_valid cycles show pos_out 0, 17, 255 in order; done once 257 cycles after start; count=3.
- Same grid, find_free=1 -> 253 valid outputs, none equal to 0, 17 or 255; count=253.
- Backpressure: cell 34 set, pos_ready low 5 cycles while pos_valid -> pos_out holds 34 for 6 cycles; count=1; done 262 cycles after start.
- Empty grid with find_free=0 -> no pos_valid, count=0. Full grid with find_free=0 -> 256 outputs, count=256.
- Start ignored when busy, and grid changed mid-scan -> results match the snapshot at the start edge; exactly one done.
- abort at idx 100 with a handshake pending -> IDLE next cycle, no done, that transfer not counted. reset_n pulsed mid-scan -> all outputs 0 immediately (asynchronously); a fresh start then works normally.

Source files
------------

// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and constants for the snake game grid logic. Used by the
// position-to-grid converter, the grid-to-position scanner and the food
// generator.
//   GRID_DIM   : cells per row and per column (fixed at 16)
//   NUM_CELLS  : total cells in the grid
//   POS_W      : width of a linear cell position (row*16+col)
//   CNT_W      : width of a match counter; must hold NUM_CELLS itself
// ---------------------------------------------------------------------------
package snake_pkg;

    localparam int GRID_DIM  = 16;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;
    localparam int POS_W     = 8;
    localparam int CNT_W     = 9;

    // grid[row][col]
    typedef logic [GRID_DIM-1:0][GRID_DIM-1:0] grid_t;
    typedef logic [POS_W-1:0]                  pos_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/grid2pos_scan.sv
// ---------------------------------------------------------------------------
// grid2pos_scan
// Snapshots a 16x16 occupancy grid and walks it in row-major order, emitting
// the linear position of every matching cell on a valid/ready stream.
// Matching means occupied (find_free=0) or free (find_free=1). The number of
// accepted positions is reported on count when the scan finishes.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a scan (looked at only in IDLE)
//   find_free  in   0: emit occupied cells, 1: emit free cells; latched at start
//   abort      in   synchronous cancel of a running scan
//   grid       in   occupancy grid, grid[row][col]
//   pos_out    out  current matching position, row*16+col
//   pos_valid  out  pos_out is a matching cell
//   pos_ready  in   consumer accepts pos_out
//   busy       out  scan in progress
//   done       out  one-cycle pulse when a scan completes
//   count      out  matches accepted in the last scan (0..256)
//
// State | meaning
// IDLE  | waiting for start; count shows the previous result
// SCAN  | examining cell idx; holds on a match until handshake
// DONE  | one-cycle completion pulse, then back to IDLE
// ---------------------------------------------------------------------------
module grid2pos_scan
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             find_free,
    input  logic             abort,
    input  grid_t            grid,
    output pos_t             pos_out,
    output logic             pos_valid,
    input  logic             pos_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam pos_t LAST_IDX = pos_t'(NUM_CELLS - 1);

    scan_state_t      state_q;
    grid_t            snap_q;
    logic             find_free_q;
    pos_t             idx_q;
    logic [CNT_W-1:0] count_q;

    logic cell_bit;
    logic match;

    // All outputs decode purely from registers, so neither grid nor
    // pos_ready has a combinational path to the stream.
    assign cell_bit  = snap_q[idx_q[7:4]][idx_q[3:0]];
    assign match     = (cell_bit != find_free_q);

    assign busy      = (state_q == SCAN);
    assign done      = (state_q == DONE);
    assign pos_valid = busy && match;
    assign pos_out   = busy ? idx_q : '0;
    assign count     = count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            find_free_q <= 1'b0;
            idx_q       <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q      <= grid;
                        find_free_q <= find_free;
                        idx_q       <= '0;
                        count_q     <= '0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    // abort wins over a same-cycle handshake; that transfer
                    // is dropped and not counted.
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (!match || pos_ready) begin
                        if (match) begin
                            count_q <= count_q + CNT_W'(1);
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            idx_q <= idx_q + pos_t'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
